ascon_pc: RTL and testbench

ASCON_PC -- requirements
Module: ascon_pc

---
 rtl/ascon_pc.sv | 63 ++++++
 tb/tb_ascon_pc.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/ascon_pc.sv
// ASCON constant-addition layer (p_C): XORs the round constant into the low byte of x2.
// The result is registered, so there is no combinational path from any input to an output.
module ascon_pc (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  input  logic [3:0]   round_i,
  input  logic [319:0] S_i,
  output logic         valid_o,
  output logic [319:0] S_o
);

  // Round constant table; indices 12..15 give a zero constant, so the state passes through unchanged.
  function automatic logic [7:0] round_const(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd0:    c = 8'hF0;
      4'd1:    c = 8'hE1;
      4'd2:    c = 8'hD2;
      4'd3:    c = 8'hC3;
      4'd4:    c = 8'hB4;
      4'd5:    c = 8'hA5;
      4'd6:    c = 8'h96;
      4'd7:    c = 8'h87;
      4'd8:    c = 8'h78;
      4'd9:    c = 8'h69;
      4'd10:   c = 8'h5A;
      4'd11:   c = 8'h4B;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  logic [319:0] state_s;
  logic [319:0] state_r;
  logic         valid_r;

  // Next state: capture the constant-added input state when valid, otherwise hold.
  always_comb begin
    state_s = state_r;
    if (valid_i) begin
      state_s            = S_i;
      state_s[135:128]   = S_i[135:128] ^ round_const(round_i);
    end else begin
      state_s = state_r;
    end
  end

  // Output registers, cleared asynchronously so an in-flight result is discarded on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= 320'h0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      valid_r <= valid_i;
    end
  end

  assign S_o     = state_r;
  assign valid_o = valid_r;

endmodule

// File: tb/tb_ascon_pc.sv
// Directed bench for ascon_pc: hand-computed vectors checked with immediate assertions.
module tb_ascon_pc;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic [3:0]   round_i;
  logic [319:0] S_i;
  logic         valid_o;
  logic [319:0] S_o;

  int vecs = 0;
  int errs = 0;

  logic [7:0]   ctab [16];
  logic [319:0] base;
  logic [319:0] exp_s;

  ascon_pc dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .round_i (round_i),
    .S_i     (S_i),
    .valid_o (valid_o),
    .S_o     (S_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    ctab = '{8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5, 8'h96, 8'h87,
             8'h78, 8'h69, 8'h5A, 8'h4B, 8'h00, 8'h00, 8'h00, 8'h00};
    base = {64'h0, {4{64'hfeedfacecafebeef}}};

    // Reset state, before any clock edge
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    round_i = 4'd0;
    S_i     = base;
    #1;
    chk("rst_valid", {319'h0, valid_o}, 320'h0);
    chk("rst_state", S_o, 320'h0);

    // Release reset with valid_i low: nothing captured
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("idle_valid", {319'h0, valid_o}, 320'h0);
    chk("idle_state", S_o, 320'h0);

    // round 0
    valid_i = 1'b1;
    round_i = 4'd0;
    @(negedge clk_i);
    chk("r0_valid", {319'h0, valid_o}, 320'h1);
    chk("r0_x2", {256'h0, S_o[191:128]}, {256'h0, 64'hfeedfacecafebe1f});
    exp_s = base;
    exp_s[191:128] = 64'hfeedfacecafebe1f;
    chk("r0_full", S_o, exp_s);

    // round 5
    round_i = 4'd5;
    @(negedge clk_i);
    chk("r5_x2", {256'h0, S_o[191:128]}, {256'h0, 64'hfeedfacecafebe4a});
    exp_s = base;
    exp_s[191:128] = 64'hfeedfacecafebe4a;
    chk("r5_full", S_o, exp_s);

    // round 11
    round_i = 4'd11;
    @(negedge clk_i);
    chk("r11_x2", {256'h0, S_o[191:128]}, {256'h0, 64'hfeedfacecafebea4});

    // Back-to-back sweep 0..11, one result per cycle
    for (int r = 0; r < 12; r++) begin
      round_i = r[3:0];
      @(negedge clk_i);
      exp_s = base;
      exp_s[135:128] = 8'hEF ^ ctab[r];
      chk($sformatf("sweep_r%0d", r), S_o, exp_s);
      chk($sformatf("sweep_v%0d", r), {319'h0, valid_o}, 320'h1);
    end

    // Pass-through rounds
    round_i = 4'd12;
    @(negedge clk_i);
    chk("r12_pass", S_o, base);
    round_i = 4'd15;
    @(negedge clk_i);
    chk("r15_pass", S_o, base);

    // Hold when valid_i is low, even if inputs change
    valid_i = 1'b0;
    S_i     = {5{64'h0123456789abcdef}};
    round_i = 4'd2;
    @(negedge clk_i);
    chk("hold_valid", {319'h0, valid_o}, 320'h0);
    chk("hold_state", S_o, base);

    // All-zero state, round 3
    valid_i = 1'b1;
    S_i     = 320'h0;
    round_i = 4'd3;
    @(negedge clk_i);
    exp_s = 320'h0;
    exp_s[135:128] = 8'hC3;
    chk("zero_r3", S_o, exp_s);

    // Mid-stream asynchronous reset
    S_i     = base;
    round_i = 4'd1;
    @(negedge clk_i);
    chk("pre_rst_valid", {319'h0, valid_o}, 320'h1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_valid", {319'h0, valid_o}, 320'h0);
    chk("async_rst_state", S_o, 320'h0);
    valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("post_rst_valid", {319'h0, valid_o}, 320'h0);
    chk("post_rst_state", S_o, 320'h0);

    // First capture after reset
    valid_i = 1'b1;
    round_i = 4'd7;
    @(negedge clk_i);
    exp_s = base;
    exp_s[135:128] = 8'hEF ^ 8'h87;
    chk("post_rst_capture", S_o, exp_s);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
